if_id_stage: RTL
================

Name: if_id_stage

Overview:
- Fetch-to-decode pipeline stage sitting directly downstream of fetch_stage.
- Pairs each synchronous inst SRAM read (request issued cycle N, data valid during N+1) with its PC.
- Absorbs the one in-flight read that completes while decode is stalled in a 2-entry skid buffer.
- Presents a registered {valid, pc, inst, delay-slot, AdEL} bundle to decode; flushable on exception/eret.

Parameters:
- RESET_PC, 32'hbfc00000, reset value of id_pc and of both buffer PC fields.
- CHECK_ALIGN, 1, when 1 flag pc[1:0]!=0 as AdEL; when 0 id_adel is tied 0.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_sram_en  in  1  fetch issued a read this cycle.
- pc  in  32  address of the read issued this cycle.
- inst_sram_rdata  in  32  SRAM read data, valid the cycle after the request.
- stall  in  1  decode cannot accept a new instruction this cycle.
- flush  in  1  discard everything in flight and in ID.
- id_is_branch  in  1  decoder: the instruction currently in ID is a branch/jump (combinational on id_inst).
- id_valid  out  1  ID slot holds a live instruction.
- id_pc  out  32  PC of the ID instruction.
- id_inst  out  32  instruction word; 32'h0 (nop) when id_adel=1.
- id_in_delay_slot  out  1  ID instruction is the delay slot of the previous instruction.
- id_adel  out  1  instruction fetch address error.
- skid_full  out  1  both skid entries occupied (debug/assert).

Behaviour:
- Internal registers:
  - req_valid/req_pc: outstanding read. Updated every edge: req_valid<=inst_sram_en & ~flush; req_pc<=pc.
  - Skid FIFO h0 (head), h1 (tail): each holds {valid, pc, inst}.
- Async reset (resetn=0): all valid bits 0, id_pc=req_pc=h*.pc=RESET_PC, id_inst=0, id_in_delay_slot=0, id_adel=0, skid_full=0. Reset mid-operation discards all state.
- Define "arrival" = req_valid=1 this cycle, with word {req_pc, inst_sram_rdata}.
- Priority per edge is flush > stall > advance.
  - flush=1: id_valid, req_valid, h0.valid, h1.valid <= 0; id_in_delay_slot<=0. A request issued in the same cycle as flush is also dropped.
  - stall=1: ID registers hold.
    - Arrival pushes to the first free skid entry (h0, else h1).
    - Arrival with both entries full is illegal; flag via assertion, data dropped.
  - stall=0 (advance): ID loads from h0 if h0.valid, else from the arrival, else id_valid<=0.
    - When h0 is consumed: h1 shifts to h0, and any arrival is pushed behind the remaining entries.
- On every ID load of a live word:
  - id_in_delay_slot <= id_valid & id_is_branch, sampled before the update.
  - id_adel <= CHECK_ALIGN & (pc[1:0]!=0); id_inst <= id_adel ? 0 : word.
  - id_pc <= word pc.
- id_valid<=0 leaves id_pc/id_inst unchanged; id_in_delay_slot<=0.
- Latency: request at cycle N gives id_valid at edge ending N+1 (visible N+2) when no stall.
- Throughput: 1 instr/cycle.
- skid_full = h0.valid & h1.valid.
- Ordering is strictly program order. No word is duplicated or lost across any stall/flush pattern except on flush.

Test Plan:
- Reset then requests pc=bfc00000, bfc00004, bfc00008 back-to-back, rdata=pc^32'h1111 -> id_valid rises 2 cycles after first request; id_pc sequence 00,04,08 on consecutive cycles; id_inst matches.
- Request bfc00010, stall=1 next 3 cycles (en=0) -> word captured in h0, ID held; stall drops -> id_pc=bfc00010 next edge, h0 empty.
- Stall asserted while two consecutive arrivals occur (en held 1 one cycle into stall) -> skid_full=1; release -> ID shows both in order over 2 cycles, then skid_full=0.
- ID holds a branch (id_is_branch=1), next word bfc00020 loads -> id_in_delay_slot=1. Following word -> id_in_delay_slot=0.
- Request pc=bfc00022, rdata=32'h24020001 -> id_adel=1, id_inst=0, id_pc=bfc00022.
- With h0 valid and req_valid=1, assert flush one cycle -> id_valid=0, skid empty; next request bfc00380 -> id_pc=bfc00380, id_in_delay_slot=0. Drop resetn mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/if_id_stage.sv
// Fetch-to-decode stage: pairs each synchronous inst SRAM read with its PC,
// absorbs reads that land while decode is stalled, and presents the ID bundle.
module if_id_stage #(
  parameter logic [31:0] RESET_PC    = 32'hbfc00000,
  parameter int          CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] pc,
  input  logic [31:0] inst_sram_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_is_branch,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_in_delay_slot,
  output logic        id_adel,
  output logic        skid_full
);

  localparam logic CHK = (CHECK_ALIGN != 0);

  // Handshake: a word moves from the arrival/skid side into ID on any edge
  // where it is valid and stall is low; while stall is high every arriving
  // word must find a free skid entry (decode never back-pressures fetch).

  logic        r_req_valid;
  logic [31:0] r_req_pc;

  logic        r_h0_valid;
  logic [31:0] r_h0_pc;
  logic [31:0] r_h0_inst;
  logic        r_h1_valid;
  logic [31:0] r_h1_pc;
  logic [31:0] r_h1_inst;

  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_ds;
  logic        r_id_adel;

  logic        w_arr;
  logic        w_h0_valid_n;
  logic [31:0] w_h0_pc_n;
  logic [31:0] w_h0_inst_n;
  logic        w_h1_valid_n;
  logic [31:0] w_h1_pc_n;
  logic [31:0] w_h1_inst_n;
  logic        w_load;
  logic [31:0] w_load_pc;
  logic [31:0] w_load_inst;
  logic        w_load_adel;

  assign w_arr = r_req_valid;

  // Outstanding request: the SRAM returns data for r_req_pc this cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_req_valid <= 1'b0;
      r_req_pc    <= RESET_PC;
    end else begin
      r_req_valid <= inst_sram_en & ~flush;
      r_req_pc    <= pc;
    end
  end

  // Skid next-state and ID source selection.
  always_comb begin
    w_h0_valid_n = r_h0_valid;
    w_h0_pc_n    = r_h0_pc;
    w_h0_inst_n  = r_h0_inst;
    w_h1_valid_n = r_h1_valid;
    w_h1_pc_n    = r_h1_pc;
    w_h1_inst_n  = r_h1_inst;
    w_load       = 1'b0;
    w_load_pc    = r_req_pc;
    w_load_inst  = inst_sram_rdata;

    if (flush) begin
      w_h0_valid_n = 1'b0;
      w_h1_valid_n = 1'b0;
    end else if (stall) begin
      if (w_arr) begin
        if (!r_h0_valid) begin
          w_h0_valid_n = 1'b1;
          w_h0_pc_n    = r_req_pc;
          w_h0_inst_n  = inst_sram_rdata;
        end else if (!r_h1_valid) begin
          w_h1_valid_n = 1'b1;
          w_h1_pc_n    = r_req_pc;
          w_h1_inst_n  = inst_sram_rdata;
        end
      end
    end else begin
      if (r_h0_valid) begin
        w_load      = 1'b1;
        w_load_pc   = r_h0_pc;
        w_load_inst = r_h0_inst;
        if (r_h1_valid) begin
          w_h0_valid_n = 1'b1;
          w_h0_pc_n    = r_h1_pc;
          w_h0_inst_n  = r_h1_inst;
          w_h1_valid_n = w_arr;
          if (w_arr) begin
            w_h1_pc_n   = r_req_pc;
            w_h1_inst_n = inst_sram_rdata;
          end
        end else begin
          w_h1_valid_n = 1'b0;
          w_h0_valid_n = w_arr;
          if (w_arr) begin
            w_h0_pc_n   = r_req_pc;
            w_h0_inst_n = inst_sram_rdata;
          end
        end
      end else if (w_arr) begin
        w_load = 1'b1;
      end
    end
  end

  assign w_load_adel = CHK & (w_load_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_h0_valid <= 1'b0;
      r_h0_pc    <= RESET_PC;
      r_h0_inst  <= 32'h0;
      r_h1_valid <= 1'b0;
      r_h1_pc    <= RESET_PC;
      r_h1_inst  <= 32'h0;
    end else begin
      r_h0_valid <= w_h0_valid_n;
      r_h0_pc    <= w_h0_pc_n;
      r_h0_inst  <= w_h0_inst_n;
      r_h1_valid <= w_h1_valid_n;
      r_h1_pc    <= w_h1_pc_n;
      r_h1_inst  <= w_h1_inst_n;
    end
  end

  // ID registers; delay-slot flag uses the ID contents before this edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= RESET_PC;
      r_id_inst  <= 32'h0;
      r_id_ds    <= 1'b0;
      r_id_adel  <= 1'b0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
      r_id_ds    <= 1'b0;
    end else if (!stall) begin
      if (w_load) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= w_load_pc;
        r_id_inst  <= w_load_adel ? 32'h0 : w_load_inst;
        r_id_ds    <= r_id_valid & id_is_branch;
        r_id_adel  <= w_load_adel;
      end else begin
        r_id_valid <= 1'b0;
        r_id_ds    <= 1'b0;
      end
    end
  end

  assign id_valid         = r_id_valid;
  assign id_pc            = r_id_pc;
  assign id_inst          = r_id_inst;
  assign id_in_delay_slot = r_id_ds;
  assign id_adel          = r_id_adel;
  assign skid_full        = r_h0_valid & r_h1_valid;

  // A word arriving while stalled with both entries occupied would be lost.
  a_no_skid_overflow : assert property (@(posedge clk) disable iff (!resetn)
    !(!flush && stall && r_req_valid && r_h0_valid && r_h1_valid));

endmodule
